instr_issue: RTL and testbench
==============================

# instr_issue

Instruction issue front end for the lab CPU datapath. It sits directly upstream of the datapath controller and accepts 16-bit instructions over a valid/ready handshake into a small FIFO. It latches one instruction at a time into an instruction register, decodes its fields and pulses `start` when the controller is waiting. Decoded fields stay stable until the controller returns to its wait state.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries; a power of two, minimum 2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: instruction source has a word.
- `in_instr` in 16: instruction word.
- `in_ready` out 1: FIFO can accept a word.
- `waiting` in 1: controller is in its wait state.
- `reg_sel` in 2: controller register select; 00=Rm, 01=Rd, 10=Rn.
- `start` out 1: one-cycle issue pulse to the controller.
- `opcode` out 3: IR[15:13].
- `ALU_op` out 2: IR[12:11].
- `shift_op` out 2: IR[4:3].
- `reg_num` out 3: register number muxed by `reg_sel`.
- `sximm8` out 16: IR[7:0] sign-extended.
- `sximm5` out 16: IR[4:0] sign-extended.
- `busy` out 1: high in the ISSUE or BUSY state.
- `illegal` out 1: sticky flag, set when an illegal instruction is dropped.

## Operation
- **Legal encodings:** opcode 110 with ALU_op 10 (MOV imm); opcode 110 with ALU_op 00 (MOV); opcode 101 with any ALU_op (ADD, CMP, AND, MVN). All other encodings are illegal.
- **Push:** occurs when `in_valid & in_ready`. `in_ready` = !full, forced to 0 while `rst_n`=0.
- **IDLE:** when the FIFO is not empty, pop the head.
  - Legal instruction and `waiting`=1: load IR, go to ISSUE.
  - Illegal instruction: pop it regardless of `waiting`, set `illegal`, leave IR unchanged, stay in IDLE.
  - Legal instruction and `waiting`=0: no pop.
- **ISSUE:** `start`=1 for this cycle only; go to BUSY.
- **BUSY:** hold IR. Return to IDLE when `waiting`=1 is sampled. This also covers an opcode the controller ignores, which keeps `waiting` high.
- **Push and pop in the same cycle:** both occur; the count is unchanged.
- **Pointer wrap-around:** pointers are modulo DEPTH.
- **reg_num:** combinational. 00→IR[2:0], 01→IR[7:5], 10→IR[10:8], 11→000.
- **Decoded outputs:** driven from IR only, never from the FIFO head.

## Timing
- Reset values: IR=0, state IDLE, FIFO empty, `start`=0, `busy`=0, `illegal`=0. All decoded outputs are 0; `reg_num` is 0 when `reg_sel`=00.
- Latency, empty FIFO with `waiting`=1:
  - Push at edge k.
  - IR loaded at edge k+1.
  - `start` high during the cycle between edges k+1 and k+2.
- Minimum issue-to-issue spacing is 3 cycles plus the controller's busy time.
- Reset asserted mid-ISSUE or mid-BUSY: the next edge returns to IDLE, empties the FIFO (contents lost) and clears `illegal`.
- `illegal` is cleared only by reset.

## Structure
- **Shared package `cpu_pkg`:** opcode constants (OP_MOV=3'b110, OP_ALU=3'b101), ALU_op constants, reg_sel encodings (SEL_RM, SEL_RD, SEL_RN), and the enum `issue_state_t` {IDLE, ISSUE, BUSY}.
- **Sub-module `instr_fifo`:** parameterised synchronous FIFO with push/pop, `full`, `empty` and head data. `instr_issue` contains the FSM, IR and decode.

## Test plan
- **Reset:** hold `rst_n`=0 with `in_valid`=1 → `in_ready`=0 and no push. Release → all outputs 0, `in_ready`=1.
- **ADD issue:** push 16'hA1A2 (101 00 001 101 00 010) with `waiting`=1 → `start` pulses exactly once, 2 cycles after the push edge. `opcode`=101, `ALU_op`=00. `reg_num` = 1 for `reg_sel`=10, 5 for 01, 2 for 00.
- **MOV imm:** push 16'hD080 → `sximm8`=16'hFF80, `ALU_op`=10. Push 16'hD07F → `sximm8`=16'h007F.
- **Backpressure, DEPTH=2:** hold `waiting`=0 and push 3 words → the third push stalls with `in_ready`=0. Raise `waiting` → the words issue in order, with `in_ready` returning to 1 after the first pop.
- **Illegal:** push 16'h0000, then a legal ADD → `illegal`=1 with no `start` for the first word, and the ADD issues normally.
- **Reset mid-BUSY:** drop `waiting` after `start` and assert `rst_n`=0 → `busy`=0, FIFO empty and IR=0 after one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the lab CPU front end: instruction field encodings,
// controller register-select codes and the issue FSM state type.
package cpu_pkg;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // ALU_op field IR[12:11] for OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // ALU_op field IR[12:11] for OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // Controller register-select encodings
  localparam logic [1:0] SEL_RM = 2'b00;
  localparam logic [1:0] SEL_RD = 2'b01;
  localparam logic [1:0] SEL_RN = 2'b10;

  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10
  } issue_state_t;

  // True for the encodings the datapath controller knows how to execute.
  function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
    logic [2:0] op;
    logic [1:0] alu;
    op  = instr[15:13];
    alu = instr[12:11];
    return (op == OP_ALU) ||
           ((op == OP_MOV) && ((alu == MOV_IMM) || (alu == MOV_REG)));
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding instruction words ahead of the issue FSM.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an empty FIFO never
    // exposes stale words, and leaving it out keeps it a plain RAM.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue front end: buffers incoming words, drops illegal ones,
// latches one legal instruction at a time into IR and pulses start to the
// datapath controller when it is waiting. Decoded fields come from IR only.
module instr_issue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        waiting,
  input  logic [1:0]  reg_sel,
  output logic        start,
  output logic [2:0]  opcode,
  output logic [1:0]  ALU_op,
  output logic [1:0]  shift_op,
  output logic [2:0]  reg_num,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        busy,
  output logic        illegal
);

  issue_state_t  state_q;
  logic [15:0]   ir_q;
  logic          start_q;
  logic          busy_q;
  logic          illegal_q;

  logic [15:0]   head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_legal;
  logic          load;

  // The source may only push when there is room, and never during reset.
  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready;

  // Illegal heads are discarded at once; legal heads wait for the controller.
  assign head_legal = is_legal(head);
  assign pop  = (state_q == IDLE) & ~empty & (~head_legal | waiting);
  assign load = pop & head_legal;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (in_instr),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Issue FSM with registered start/busy/illegal and the instruction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop && !head_legal) illegal_q <= 1'b1;
          if (load) begin
            ir_q    <= head;
            state_q <= ISSUE;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: state_q <= BUSY;
        BUSY: begin
          if (waiting) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start   = start_q;
  assign busy    = busy_q;
  assign illegal = illegal_q;

  // Field decode, always from the latched instruction.
  assign opcode   = ir_q[15:13];
  assign ALU_op   = ir_q[12:11];
  assign shift_op = ir_q[4:3];
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};

  // Register-number mux selected by the controller.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred even if
    // a select value is missed by the case below.
    reg_num = 3'b000;
    case (reg_sel)
      SEL_RM:  reg_num = ir_q[2:0];
      SEL_RD:  reg_num = ir_q[7:5];
      SEL_RN:  reg_num = ir_q[10:8];
      default: reg_num = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: directed scenarios followed by a
// randomized run, all compared against a transaction-level model of the
// issue front end (a word queue plus issue/busy flags).
module tb_instr_issue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        waiting;
  logic [1:0]  reg_sel;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op;
  logic [1:0]  shift_op;
  logic [2:0]  reg_num;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        busy;
  logic        illegal;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_ir;
  bit          m_start;
  bit          m_busy;
  bit          m_illegal;

  always #5 clk = ~clk;

  instr_issue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .waiting  (waiting),
    .reg_sel  (reg_sel),
    .start    (start),
    .opcode   (opcode),
    .ALU_op   (ALU_op),
    .shift_op (shift_op),
    .reg_num  (reg_num),
    .sximm8   (sximm8),
    .sximm5   (sximm5),
    .busy     (busy),
    .illegal  (illegal)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input logic [15:0] w);
    int op;
    int alu;
    op  = int'(w >> 13) & 7;
    alu = int'(w >> 11) & 3;
    return (op == 5) || (op == 6 && (alu == 0 || alu == 2));
  endfunction

  function automatic logic [15:0] sext(input int v, input int bits);
    int r;
    r = v & ((1 << bits) - 1);
    if (r >= (1 << (bits - 1))) r = r - (1 << bits);
    return 16'(r);
  endfunction

  // Model: advance one clock edge using the inputs present before the edge.
  task automatic model_edge();
    bit can_push;
    if (!rst_n) begin
      mq.delete();
      m_ir = 16'h0; m_start = 0; m_busy = 0; m_illegal = 0;
      return;
    end
    can_push = in_valid && (mq.size() < DEPTH);
    if (!m_busy) begin
      m_start = 0;
      if (mq.size() > 0) begin
        if (!legal_m(mq[0])) begin
          void'(mq.pop_front());
          m_illegal = 1;
        end else if (waiting) begin
          m_ir = mq.pop_front();
          m_start = 1;
          m_busy = 1;
        end
      end
    end else if (m_start) begin
      m_start = 0;
    end else if (waiting) begin
      m_busy = 0;
    end
    if (can_push) mq.push_back(in_instr);
  endtask

  task automatic check_all();
    int ir;
    logic [2:0] rn;
    ir = int'(m_ir);
    case (reg_sel)
      2'd0:    rn = 3'(ir % 8);
      2'd1:    rn = 3'((ir / 32) % 8);
      2'd2:    rn = 3'((ir / 256) % 8);
      default: rn = 3'd0;
    endcase
    check("in_ready", 16'(in_ready), 16'(rst_n && (mq.size() < DEPTH)));
    check("start",    16'(start),    16'(m_start));
    check("busy",     16'(busy),     16'(m_busy));
    check("illegal",  16'(illegal),  16'(m_illegal));
    check("opcode",   16'(opcode),   16'((ir / 8192) % 8));
    check("ALU_op",   16'(ALU_op),   16'((ir / 2048) % 4));
    check("shift_op", 16'(shift_op), 16'((ir / 8) % 4));
    check("reg_num",  16'(reg_num),  16'(rn));
    check("sximm8",   sximm8,        sext(ir, 8));
    check("sximm5",   sximm5,        sext(ir, 5));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int idx;
    logic [15:0] bp_words [3];
    bp_words[0] = 16'hB001;
    bp_words[1] = 16'hB102;
    bp_words[2] = 16'hB203;

    // Reset with a word offered: nothing may be accepted.
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 16'hA1A2; waiting = 1'b1; reg_sel = 2'b00;
    @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h0);
    cycle();
    cycle();
    check("rst_in_ready_held", 16'(in_ready), 16'h0);
    in_valid = 1'b0; rst_n = 1'b1;
    cycle();
    check("post_rst_ready", 16'(in_ready), 16'h1);
    check("post_rst_start", 16'(start), 16'h0);
    check("post_rst_sximm8", sximm8, 16'h0000);

    // ADD issue: start two edges after the push edge.
    in_valid = 1'b1; in_instr = 16'hA1A2;
    cycle();
    in_valid = 1'b0;
    check("add_no_start_k", 16'(start), 16'h0);
    cycle();
    check("add_start", 16'(start), 16'h1);
    check("add_opcode", 16'(opcode), 16'h5);
    check("add_aluop", 16'(ALU_op), 16'h0);
    reg_sel = 2'b10; #1; check("add_rn", 16'(reg_num), 16'd1);
    reg_sel = 2'b01; #1; check("add_rd", 16'(reg_num), 16'd5);
    reg_sel = 2'b00; #1; check("add_rm", 16'(reg_num), 16'd2);
    reg_sel = 2'b11; #1; check("add_sel11", 16'(reg_num), 16'd0);
    reg_sel = 2'b00;
    cycle();
    check("add_start_once", 16'(start), 16'h0);
    check("add_busy", 16'(busy), 16'h1);
    cycle();
    check("add_back_idle", 16'(busy), 16'h0);

    // MOV immediate, negative and positive byte.
    in_valid = 1'b1; in_instr = 16'hD080;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("movn_sximm8", sximm8, 16'hFF80);
    check("movn_aluop", 16'(ALU_op), 16'h2);
    cycle(); cycle();
    in_valid = 1'b1; in_instr = 16'hD07F;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("movp_sximm8", sximm8, 16'h007F);
    cycle(); cycle();

    // Backpressure: controller not waiting, third word stalls.
    waiting = 1'b0; in_valid = 1'b1;
    in_instr = bp_words[0]; cycle();
    in_instr = bp_words[1]; cycle();
    check("bp_full", 16'(in_ready), 16'h0);
    in_instr = bp_words[2]; cycle();
    check("bp_stall", 16'(in_ready), 16'h0);
    waiting = 1'b1;
    cycle();
    check("bp_ready_after_pop", 16'(in_ready), 16'h1);
    check("bp_first_start", 16'(start), 16'h1);
    check("bp_first_word", sximm8, 16'h0001);
    cycle();
    in_valid = 1'b0;
    idx = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (start) begin
        if (idx < 3) check("bp_order", sximm8, 16'(bp_words[idx][7:0]));
        idx++;
      end
    end
    check("bp_issue_count", 16'(idx), 16'd3);

    // Illegal word dropped, following ADD issues.
    in_valid = 1'b1; in_instr = 16'h0000;
    cycle();
    in_instr = 16'hA1A2;
    cycle();
    in_valid = 1'b0;
    check("ill_flag", 16'(illegal), 16'h1);
    check("ill_no_start", 16'(start), 16'h0);
    cycle();
    check("ill_add_start", 16'(start), 16'h1);
    check("ill_add_opcode", 16'(opcode), 16'h5);
    cycle(); cycle();
    check("ill_sticky", 16'(illegal), 16'h1);

    // Reset while BUSY with words queued.
    in_valid = 1'b1; in_instr = 16'hA1A2;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("rb_start", 16'(start), 16'h1);
    waiting = 1'b0; in_valid = 1'b1; in_instr = 16'hB001;
    cycle();
    check("rb_busy", 16'(busy), 16'h1);
    cycle();
    in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    check("rb_busy_clr", 16'(busy), 16'h0);
    check("rb_illegal_clr", 16'(illegal), 16'h0);
    check("rb_ir_clr", sximm8, 16'h0000);
    check("rb_opcode_clr", 16'(opcode), 16'h0);
    rst_n = 1'b1; waiting = 1'b1;
    cycle();
    check("rb_ready", 16'(in_ready), 16'h1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rb_fifo_empty", 16'(start), 16'h0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(63) != 0);
      in_valid = $urandom_range(1);
      in_instr = 16'($urandom);
      if ($urandom_range(3) != 0)
        in_instr[15:13] = ($urandom_range(1) != 0) ? 3'b101 : 3'b110;
      waiting  = ($urandom_range(3) != 0);
      reg_sel  = 2'($urandom_range(3));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
